// File: rtl/rs_decoder_76_64_pkg.sv
// rs_76_64_pkg
// Shared constants, state encoding, result record and GF(256) arithmetic
// for the RS(76,64) decoder. Field is GF(2^8) with primitive polynomial
// x^8+x^4+x^3+x^2+1 (0x11D) and alpha = 0x02.
package rs_76_64_pkg;

    localparam int N    = 76;
    localparam int K    = 64;
    localparam int NPAR = 12;

    // Low byte of the primitive polynomial; x^8 is implied by the shift-out.
    localparam logic [7:0] GF_POLY = 8'h1D;
    localparam logic [7:0] ALPHA   = 8'h02;

    // alpha^i for i = 0..11, element i sits at index i.
    localparam logic [NPAR-1:0][7:0] ALPHA_POW = {
        8'hE8, 8'h74, 8'h3A, 8'h1D, 8'h80, 8'h40,
        8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01
    };

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYN  = 3'd1,
        ST_CHK  = 3'd2,
        ST_SRCH = 3'd3,
        ST_VER  = 3'd4,
        ST_FIX  = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    // Status reported with every finished decode.
    typedef struct packed {
        logic       err_detected;
        logic       corrected;
        logic       uncorrectable;
        logic [6:0] err_pos;
        logic [7:0] err_val;
    } result_t;

    localparam result_t RES_CLEAN  = '0;
    localparam result_t RES_UNCORR = '{
        err_detected:  1'b1,
        corrected:     1'b0,
        uncorrectable: 1'b1,
        err_pos:       7'd0,
        err_val:       8'd0
    };

    // Shift-and-add multiply; with a constant operand synthesis reduces this
    // to a small XOR network.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end
            sh = sh[7] ? ({sh[6:0], 1'b0} ^ GF_POLY) : {sh[6:0], 1'b0};
        end
        return acc;
    endfunction

endpackage

// File: rtl/rs_decoder_76_64_if.sv
// rs_decoder_76_64_if
// Request/result bundle between the storage side and the decoder.
//   start          request pulse, sampled while the decoder is idle
//   code_in        608-bit received codeword, symbol k at bits 8k+7:8k
//   data_out       512-bit data symbols 75..12 (bits 511:504 = symbol 75)
//   valid_out      result valid, held until start is low
//   err_detected   any syndrome nonzero
//   corrected      single-symbol error located and fixed
//   uncorrectable  error present but not correctable
//   err_pos        located symbol index, 0 when nothing was corrected
//   err_val        error magnitude applied, 0 when nothing was corrected
// master = requester/consumer side, slave = decoder side.
interface rs_decoder_76_64_if;
    import rs_76_64_pkg::*;

    logic                start;
    logic [N*8-1:0]      code_in;
    logic [K*8-1:0]      data_out;
    logic                valid_out;
    logic                err_detected;
    logic                corrected;
    logic                uncorrectable;
    logic [6:0]          err_pos;
    logic [7:0]          err_val;

    modport master (
        output start,
        output code_in,
        input  data_out,
        input  valid_out,
        input  err_detected,
        input  corrected,
        input  uncorrectable,
        input  err_pos,
        input  err_val
    );

    modport slave (
        input  start,
        input  code_in,
        output data_out,
        output valid_out,
        output err_detected,
        output corrected,
        output uncorrectable,
        output err_pos,
        output err_val
    );

endinterface

// File: rtl/rs_decoder_76_64_gfmul.sv
// gf256_mult
// Purely combinational general GF(256) multiplier (poly 0x11D).
//   i_a, i_b   operands
//   o_p        product i_a * i_b
module gf256_mult
    import rs_76_64_pkg::*;
(
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    output logic [7:0] o_p
);

    // Partial products i_a * x^n, reduced as they are formed.
    logic [7:0][7:0] w_pp;

    always_comb begin
        w_pp[0] = i_a;
        for (int n = 1; n < 8; n++) begin
            w_pp[n] = w_pp[n-1][7] ? ({w_pp[n-1][6:0], 1'b0} ^ GF_POLY)
                                   : {w_pp[n-1][6:0], 1'b0};
        end
    end

    always_comb begin
        o_p = 8'h00;
        for (int n = 0; n < 8; n++) begin
            if (i_b[n]) begin
                o_p = o_p ^ w_pp[n];
            end
        end
    end

endmodule

// File: rtl/rs_decoder_76_64_syndrome.sv
// rs_syndrome_bank_76
// Twelve syndrome accumulators S0..S11, each evaluating the received
// polynomial at alpha^i by Horner's rule, highest symbol first.
//   clk, rst   clock and synchronous active-high reset
//   i_clr      zero all syndromes (has priority over i_en)
//   i_en       fold i_sym into every syndrome this cycle
//   i_sym      current received symbol
//   o_syn      S0..S11, S_i at index i
module rs_syndrome_bank_76
    import rs_76_64_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic                  i_en,
    input  logic [7:0]            i_sym,
    output logic [NPAR-1:0][7:0]  o_syn
);

    logic [NPAR-1:0][7:0] r_syn;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_syn <= '0;
        end else if (i_clr) begin
            r_syn <= '0;
        end else if (i_en) begin
            for (int i = 0; i < NPAR; i++) begin
                r_syn[i] <= gf_mul(r_syn[i], ALPHA_POW[i]) ^ i_sym;
            end
        end
    end

    assign o_syn = r_syn;

endmodule

// File: rtl/rs_decoder_76_64.sv
// rs_decoder_76_64
// Sequential RS(76,64) decoder: syndromes, single-symbol locate by
// linear search, full consistency check across all twelve syndromes,
// then in-place correction of the latched codeword.
//   clk    clock
//   rst    synchronous active-high reset, aborts any decode in progress
//   bus    rs_decoder_76_64_if slave modport (request in, result out)
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for start; codeword latched on the start edge
// SYN     | 76 Horner steps, symbol 75 down to 0
// CHK     | classify syndromes: clean / S0==0 / candidate single error
// SRCH    | step t = S0*alpha^j until t == S1, j = 0..75
// VER     | confirm S(i+1) == S(i)*alpha^j for i = 0..10
// FIX     | XOR S0 into symbol j, report corrected
// DONE    | result held, valid_out high until start is low
module rs_decoder_76_64
    import rs_76_64_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    rs_decoder_76_64_if.slave    bus
);

    state_t                r_state;
    state_t                w_state_nxt;

    logic [6:0]            r_cnt;
    logic [6:0]            w_cnt_nxt;
    logic [N*8-1:0]        r_rbuf;
    logic [N*8-1:0]        w_rbuf_nxt;
    logic [7:0]            r_t;
    logic [7:0]            w_t_nxt;
    logic [7:0]            r_x;
    logic [7:0]            w_x_nxt;
    logic [6:0]            r_j;
    logic [6:0]            w_j_nxt;
    logic                  r_valid;
    logic                  w_valid_nxt;
    result_t               r_res;
    result_t               w_res_nxt;

    logic                  w_syn_clr;
    logic                  w_syn_en;
    logic [9:0]            w_sym_base;
    logic [9:0]            w_fix_base;
    logic [7:0]            w_sym;
    logic [NPAR-1:0][7:0]  w_syn;

    logic [3:0]            w_ver_idx;
    logic [7:0]            w_ver_cur;
    logic [7:0]            w_ver_next;
    logic [7:0]            w_ver_prod;

    // r_cnt doubles as the symbol index in SYN and the syndrome index in VER.
    assign w_sym_base = {r_cnt, 3'b000};
    assign w_fix_base = {r_j, 3'b000};
    assign w_sym      = r_rbuf[w_sym_base +: 8];

    rs_syndrome_bank_76 u_syn (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_syn_clr),
        .i_en  (w_syn_en),
        .i_sym (w_sym),
        .o_syn (w_syn)
    );

    assign w_ver_idx  = r_cnt[3:0];
    assign w_ver_cur  = w_syn[w_ver_idx];
    assign w_ver_next = w_syn[w_ver_idx + 4'd1];

    // r_x holds alpha^j once the search has hit.
    gf256_mult u_ver_mult (
        .i_a (w_ver_cur),
        .i_b (r_x),
        .o_p (w_ver_prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rbuf_nxt  = r_rbuf;
        w_t_nxt     = r_t;
        w_x_nxt     = r_x;
        w_j_nxt     = r_j;
        w_valid_nxt = r_valid;
        w_res_nxt   = r_res;
        w_syn_clr   = 1'b0;
        w_syn_en    = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_rbuf_nxt  = bus.code_in;
                    w_syn_clr   = 1'b1;
                    w_cnt_nxt   = 7'(N - 1);
                    w_state_nxt = ST_SYN;
                end
            end

            ST_SYN: begin
                w_syn_en = 1'b1;
                if (r_cnt == 7'd0) begin
                    w_state_nxt = ST_CHK;
                end else begin
                    w_cnt_nxt = r_cnt - 7'd1;
                end
            end

            ST_CHK: begin
                if (w_syn == '0) begin
                    w_res_nxt   = RES_CLEAN;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = ST_DONE;
                end else if (w_syn[0] == 8'h00) begin
                    // Nonzero error with zero total magnitude: at least two symbols.
                    w_res_nxt   = RES_UNCORR;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_t_nxt     = w_syn[0];
                    w_x_nxt     = 8'h01;
                    w_j_nxt     = 7'd0;
                    w_state_nxt = ST_SRCH;
                end
            end

            ST_SRCH: begin
                if (r_t == w_syn[1]) begin
                    w_cnt_nxt   = 7'd0;
                    w_state_nxt = ST_VER;
                end else if (r_j == 7'(N - 1)) begin
                    w_res_nxt   = RES_UNCORR;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_t_nxt = gf_mul(r_t, ALPHA);
                    w_x_nxt = gf_mul(r_x, ALPHA);
                    w_j_nxt = r_j + 7'd1;
                end
            end

            ST_VER: begin
                // A search hit alone can be a coincidence of a multi-symbol
                // error; only a full geometric syndrome sequence is accepted.
                if (w_ver_prod != w_ver_next) begin
                    w_res_nxt   = RES_UNCORR;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = ST_DONE;
                end else if (r_cnt == 7'(NPAR - 2)) begin
                    w_state_nxt = ST_FIX;
                end else begin
                    w_cnt_nxt = r_cnt + 7'd1;
                end
            end

            ST_FIX: begin
                w_rbuf_nxt[w_fix_base +: 8] = r_rbuf[w_fix_base +: 8] ^ w_syn[0];
                w_res_nxt = '{
                    err_detected:  1'b1,
                    corrected:     1'b1,
                    uncorrectable: 1'b0,
                    err_pos:       r_j,
                    err_val:       w_syn[0]
                };
                w_valid_nxt = 1'b1;
                w_state_nxt = ST_DONE;
            end

            ST_DONE: begin
                if (!bus.start) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_rbuf  <= '0;
            r_t     <= '0;
            r_x     <= '0;
            r_j     <= '0;
            r_valid <= 1'b0;
            r_res   <= '0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_rbuf  <= w_rbuf_nxt;
            r_t     <= w_t_nxt;
            r_x     <= w_x_nxt;
            r_j     <= w_j_nxt;
            r_valid <= w_valid_nxt;
            r_res   <= w_res_nxt;
        end
    end

    assign bus.data_out      = r_rbuf[N*8-1:NPAR*8];
    assign bus.valid_out     = r_valid;
    assign bus.err_detected  = r_res.err_detected;
    assign bus.corrected     = r_res.corrected;
    assign bus.uncorrectable = r_res.uncorrectable;
    assign bus.err_pos       = r_res.err_pos;
    assign bus.err_val       = r_res.err_val;

endmodule

// File: tb/tb_rs_decoder_76_64.sv
// tb_rs_decoder_76_64
// Self-checking bench for rs_decoder_76_64. Codewords come from an
// independent systematic encoder; expected results are queued when a
// decode is launched and compared when valid_out rises.
module tb_rs_decoder_76_64;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rs_decoder_76_64_if bus ();

    rs_decoder_76_64 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // flags = {err_detected, corrected, uncorrectable, err_pos, err_val}
    typedef struct {
        logic [511:0] data;
        logic [17:0]  flags;
        int           lat;
    } exp_t;

    exp_t         sb[$];
    int           total;
    int           bad;
    logic [7:0]   gpoly [13];
    logic [607:0] base_cw;

    function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        logic [7:0] y;
        r = 8'h00;
        x = a;
        y = b;
        while (y != 8'h00) begin
            if (y[0]) r = r ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1D) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return r;
    endfunction

    // g(x) = prod_{i=0..11} (x + alpha^i)
    task automatic build_gpoly();
        logic [7:0] a;
        for (int m = 0; m < 13; m++) gpoly[m] = 8'h00;
        gpoly[0] = 8'h01;
        a = 8'h01;
        for (int i = 0; i < 12; i++) begin
            for (int m = 12; m >= 1; m--) gpoly[m] = gpoly[m-1] ^ tb_gmul(gpoly[m], a);
            gpoly[0] = tb_gmul(gpoly[0], a);
            a = tb_gmul(a, 8'h02);
        end
    endtask

    function automatic logic [607:0] encode(input logic [511:0] d);
        logic [7:0]   r [12];
        logic [7:0]   fb;
        logic [607:0] cw;
        for (int m = 0; m < 12; m++) r[m] = 8'h00;
        for (int k = 75; k >= 12; k--) begin
            fb = d[(k-12)*8 +: 8] ^ r[11];
            for (int m = 11; m >= 1; m--) r[m] = r[m-1] ^ tb_gmul(fb, gpoly[m]);
            r[0] = tb_gmul(fb, gpoly[0]);
        end
        cw = '0;
        cw[607:96] = d;
        for (int m = 0; m < 12; m++) cw[m*8 +: 8] = r[m];
        return cw;
    endfunction

    function automatic logic [17:0] mk_flags(input logic det, input logic cor, input logic unc,
                                             input logic [6:0] pos, input logic [7:0] val);
        return {det, cor, unc, pos, val};
    endfunction

    // Launch one decode and count edges (start-sampling edge = 1) until
    // valid_out is seen high. No checking here.
    task automatic run_decode(input logic [607:0] cw, output int lat, output bit timeout);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.code_in = cw;
        bus.start   = 1'b1;
        @(posedge clk);
        lat = 1;
        #1;
        bus.start   = 1'b0;
        bus.code_in = ~cw;
        while (bus.valid_out !== 1'b1 && lat < 400) begin
            @(posedge clk);
            lat++;
            #1;
        end
        timeout = (bus.valid_out !== 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.code_in = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bus.valid_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid: got %b want 0", bus.valid_out);
        end
        total++;
        if ({bus.err_detected, bus.corrected, bus.uncorrectable, bus.err_pos, bus.err_val} !== 18'h0) begin
            bad++;
            $display("FAIL reset_flags: got %h want 0",
                     {bus.err_detected, bus.corrected, bus.uncorrectable, bus.err_pos, bus.err_val});
        end
        total++;
        if (bus.data_out !== 512'h0) begin
            bad++;
            $display("FAIL reset_data: got %h want 0", bus.data_out);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_no_error();
        exp_t e;
        int   lat;
        bit   to;
        e.data  = base_cw[607:96];
        e.flags = mk_flags(1'b0, 1'b0, 1'b0, 7'd0, 8'd0);
        e.lat   = 78;
        sb.push_back(e);
        run_decode(base_cw, lat, to);
        e = sb.pop_front();
        total++;
        if (to || lat != e.lat) begin
            bad++;
            $display("FAIL clean_latency: got %0d (timeout=%0d) want %0d", lat, to, e.lat);
        end
        total++;
        if ({bus.err_detected, bus.corrected, bus.uncorrectable, bus.err_pos, bus.err_val} !== e.flags) begin
            bad++;
            $display("FAIL clean_flags: got %h want %h",
                     {bus.err_detected, bus.corrected, bus.uncorrectable, bus.err_pos, bus.err_val}, e.flags);
        end
        total++;
        if (bus.data_out !== e.data) begin
            bad++;
            $display("FAIL clean_data: got %h want %h", bus.data_out, e.data);
        end
    endtask

    task automatic test_single_error();
        int           pos_t [5] = '{40, 0, 75, 12, 11};
        logic [7:0]   val_t [5] = '{8'h5A, 8'h01, 8'hC3, 8'h80, 8'hFF};
        exp_t         e;
        logic [607:0] cw;
        int           lat;
        bit           to;
        for (int c = 0; c < 5; c++) begin
            cw = base_cw;
            cw[pos_t[c]*8 +: 8] = cw[pos_t[c]*8 +: 8] ^ val_t[c];
            e.data  = base_cw[607:96];
            e.flags = mk_flags(1'b1, 1'b1, 1'b0, 7'(pos_t[c]), val_t[c]);
            e.lat   = 91 + pos_t[c];
            sb.push_back(e);
            run_decode(cw, lat, to);
            e = sb.pop_front();
            total++;
            if (to || lat != e.lat) begin
                bad++;
                $display("FAIL single_latency pos=%0d: got %0d (timeout=%0d) want %0d", pos_t[c], lat, to, e.lat);
            end
            total++;
            if ({bus.err_detected, bus.corrected, bus.uncorrectable, bus.err_pos, bus.err_val} !== e.flags) begin
                bad++;
                $display("FAIL single_flags pos=%0d: got %h want %h", pos_t[c],
                         {bus.err_detected, bus.corrected, bus.uncorrectable, bus.err_pos, bus.err_val}, e.flags);
            end
            total++;
            if (bus.data_out !== e.data) begin
                bad++;
                $display("FAIL single_data pos=%0d: got %h want %h", pos_t[c], bus.data_out, e.data);
            end
        end
    endtask

    task automatic test_multi_error();
        int           pa [2] = '{5, 20};
        logic [7:0]   va [2] = '{8'h11, 8'h33};
        int           pb [2] = '{60, 50};
        logic [7:0]   vb [2] = '{8'h22, 8'h33};
        int           lt [2] = '{-1, 78};
        exp_t         e;
        logic [607:0] cw;
        int           lat;
        bit           to;
        for (int c = 0; c < 2; c++) begin
            cw = base_cw;
            cw[pa[c]*8 +: 8] = cw[pa[c]*8 +: 8] ^ va[c];
            cw[pb[c]*8 +: 8] = cw[pb[c]*8 +: 8] ^ vb[c];
            e.data  = cw[607:96];
            e.flags = mk_flags(1'b1, 1'b0, 1'b1, 7'd0, 8'd0);
            e.lat   = lt[c];
            sb.push_back(e);
            run_decode(cw, lat, to);
            e = sb.pop_front();
            total++;
            if (to || (e.lat >= 0 && lat != e.lat)) begin
                bad++;
                $display("FAIL multi_latency case=%0d: got %0d (timeout=%0d) want %0d", c, lat, to, e.lat);
            end
            total++;
            if ({bus.err_detected, bus.corrected, bus.uncorrectable, bus.err_pos, bus.err_val} !== e.flags) begin
                bad++;
                $display("FAIL multi_flags case=%0d: got %h want %h", c,
                         {bus.err_detected, bus.corrected, bus.uncorrectable, bus.err_pos, bus.err_val}, e.flags);
            end
            total++;
            if (bus.data_out !== e.data) begin
                bad++;
                $display("FAIL multi_data case=%0d: got %h want %h", c, bus.data_out, e.data);
            end
        end
    endtask

    task automatic test_start_held();
        exp_t         e;
        logic [607:0] cw;
        logic         prev;
        int           rises;
        int           falls;
        int           first;
        int           lat;
        bit           to;
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        e.data  = '0;
        e.flags = mk_flags(1'b0, 1'b0, 1'b0, 7'd0, 8'd0);
        e.lat   = 78;
        sb.push_back(e);
        bus.code_in = '0;
        bus.start   = 1'b1;
        prev  = bus.valid_out;
        rises = 0;
        falls = 0;
        first = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            if (bus.valid_out === 1'b1 && prev !== 1'b1) begin
                rises++;
                if (first < 0) first = c;
            end
            if (bus.valid_out !== 1'b1 && prev === 1'b1) falls++;
            prev = bus.valid_out;
        end
        e = sb.pop_front();
        total++;
        if (rises != 1 || falls != 0) begin
            bad++;
            $display("FAIL held_single_decode: got rises=%0d falls=%0d want rises=1 falls=0", rises, falls);
        end
        total++;
        if (first != e.lat) begin
            bad++;
            $display("FAIL held_latency: got %0d want %0d", first, e.lat);
        end
        total++;
        if ({bus.err_detected, bus.corrected, bus.uncorrectable, bus.err_pos, bus.err_val} !== e.flags) begin
            bad++;
            $display("FAIL held_flags: got %h want %h",
                     {bus.err_detected, bus.corrected, bus.uncorrectable, bus.err_pos, bus.err_val}, e.flags);
        end
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (bus.valid_out !== 1'b0) begin
            bad++;
            $display("FAIL held_release_valid: got %b want 0", bus.valid_out);
        end
        cw = '0;
        cw[33*8 +: 8] = 8'h7E;
        e.data  = '0;
        e.flags = mk_flags(1'b1, 1'b1, 1'b0, 7'd33, 8'h7E);
        e.lat   = 91 + 33;
        sb.push_back(e);
        run_decode(cw, lat, to);
        e = sb.pop_front();
        total++;
        if (to || lat != e.lat) begin
            bad++;
            $display("FAIL fresh_latency: got %0d (timeout=%0d) want %0d", lat, to, e.lat);
        end
        total++;
        if ({bus.err_detected, bus.corrected, bus.uncorrectable, bus.err_pos, bus.err_val} !== e.flags) begin
            bad++;
            $display("FAIL fresh_flags: got %h want %h",
                     {bus.err_detected, bus.corrected, bus.uncorrectable, bus.err_pos, bus.err_val}, e.flags);
        end
        total++;
        if (bus.data_out !== e.data) begin
            bad++;
            $display("FAIL fresh_data: got %h want %h", bus.data_out, e.data);
        end
    endtask

    task automatic test_reset_abort();
        exp_t         e;
        logic [607:0] cw;
        int           lat;
        bit           to;
        cw = base_cw;
        cw[50*8 +: 8] = cw[50*8 +: 8] ^ 8'h09;
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.code_in = cw;
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (29) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (bus.valid_out !== 1'b0) begin
            bad++;
            $display("FAIL abort_valid: got %b want 0", bus.valid_out);
        end
        total++;
        if ({bus.err_detected, bus.corrected, bus.uncorrectable, bus.err_pos, bus.err_val} !== 18'h0) begin
            bad++;
            $display("FAIL abort_flags: got %h want 0",
                     {bus.err_detected, bus.corrected, bus.uncorrectable, bus.err_pos, bus.err_val});
        end
        total++;
        if (bus.data_out !== 512'h0) begin
            bad++;
            $display("FAIL abort_data: got %h want 0", bus.data_out);
        end
        @(negedge clk);
        rst = 1'b0;
        cw = base_cw;
        cw[17*8 +: 8] = cw[17*8 +: 8] ^ 8'h44;
        e.data  = base_cw[607:96];
        e.flags = mk_flags(1'b1, 1'b1, 1'b0, 7'd17, 8'h44);
        e.lat   = 91 + 17;
        sb.push_back(e);
        run_decode(cw, lat, to);
        e = sb.pop_front();
        total++;
        if (to || lat != e.lat) begin
            bad++;
            $display("FAIL post_abort_latency: got %0d (timeout=%0d) want %0d", lat, to, e.lat);
        end
        total++;
        if ({bus.err_detected, bus.corrected, bus.uncorrectable, bus.err_pos, bus.err_val} !== e.flags) begin
            bad++;
            $display("FAIL post_abort_flags: got %h want %h",
                     {bus.err_detected, bus.corrected, bus.uncorrectable, bus.err_pos, bus.err_val}, e.flags);
        end
        total++;
        if (bus.data_out !== e.data) begin
            bad++;
            $display("FAIL post_abort_data: got %h want %h", bus.data_out, e.data);
        end
    endtask

    initial begin
        logic [511:0] d;
        total = 0;
        bad   = 0;
        bus.start   = 1'b0;
        bus.code_in = '0;
        build_gpoly();
        // data symbols 75..12 carry 0x00..0x3F
        for (int k = 12; k < 76; k++) d[(k-12)*8 +: 8] = 8'(75 - k);
        base_cw = encode(d);

        test_reset();
        test_no_error();
        test_single_error();
        test_multi_error();
        test_start_held();
        test_reset_abort();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
